// File: rtl/pattern_loader_pkg.sv
// Shared types and constants for the pattern RAM frame loader.
// The state enum is reused by anything that needs to observe loader progress.
package pattern_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        COUNT,
        DATA,
        CHECK
    } state_t;

    localparam logic [7:0] SyncByte = 8'hA5;

endpackage

// File: rtl/timeout_timer.sv
// Idle-gap timer: a down-counter reloaded by restart; expired is asserted while
// enabled and the count has run out. Sized so that expiry is seen Cycles-1 cycles
// after the restart cycle, letting a registered consumer react exactly Cycles later.
module timeout_timer #(
    parameter int unsigned Cycles = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CountWidth = (Cycles > 2) ? $clog2(Cycles) : 1;
    localparam logic [CountWidth-1:0] Reload = CountWidth'(Cycles - 2);

    logic [CountWidth-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (restart) begin
            count <= Reload;
        end else if (enable && (count != '0)) begin
            count <= count - CountWidth'(1);
        end
    end

    assign expired = enable && (count == '0);

endmodule

// File: rtl/pattern_loader.sv
// Byte-stream frame parser writing pattern words into port A of the pattern RAM.
// Frame: SYNC, ADDR, COUNT, COUNT data bytes, CHK (XOR of everything after SYNC).
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for SYNC; other bytes dropped silently
//   ADDR  | next byte is the start address; seeds the checksum
//   COUNT | next byte is the word count; zero skips straight to CHECK
//   DATA  | each byte writes one word and advances the pointer
//   CHECK | next byte is compared to the running checksum
module pattern_loader
    import pattern_loader_pkg::*;
#(
    parameter int unsigned AddrBusWidth  = 6,
    parameter int unsigned DataBusWidth  = 4,
    parameter int unsigned TimeoutCycles = 1_000_000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic [AddrBusWidth-1:0] addr_a,
    output logic                    we_a,
    output logic [DataBusWidth-1:0] w_data_a,
    output logic                    busy,
    output logic                    frame_ok,
    output logic                    frame_err
);

    if (AddrBusWidth > 8 || AddrBusWidth < 1) begin : g_bad_addr_width
        $error("pattern_loader: AddrBusWidth must be 1..8");
    end
    if (DataBusWidth > 8 || DataBusWidth < 1) begin : g_bad_data_width
        $error("pattern_loader: DataBusWidth must be 1..8");
    end
    if (TimeoutCycles < 2) begin : g_bad_timeout
        $error("pattern_loader: TimeoutCycles must be at least 2");
    end

    state_t                  state;
    logic [AddrBusWidth-1:0] wr_ptr;
    logic [7:0]              remaining;
    logic [7:0]              checksum;
    logic                    timer_enable;
    logic                    timer_expired;

    assign timer_enable = (state != IDLE);

    timeout_timer #(
        .Cycles (TimeoutCycles)
    ) u_timeout_timer (
        .clk     (clk),
        .rst     (rst),
        .restart (rx_valid),
        .enable  (timer_enable),
        .expired (timer_expired)
    );

    // An arriving byte always takes priority over a timeout on the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            remaining <= '0;
            checksum  <= '0;
            addr_a    <= '0;
            we_a      <= 1'b0;
            w_data_a  <= '0;
            busy      <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            we_a      <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;

            if (rx_valid) begin
                case (state)
                    IDLE: begin
                        if (rx_data == SyncByte) begin
                            state <= ADDR;
                            busy  <= 1'b1;
                        end
                    end
                    ADDR: begin
                        wr_ptr   <= rx_data[AddrBusWidth-1:0];
                        checksum <= rx_data;
                        state    <= COUNT;
                    end
                    COUNT: begin
                        remaining <= rx_data;
                        checksum  <= checksum ^ rx_data;
                        state     <= (rx_data == 8'd0) ? CHECK : DATA;
                    end
                    DATA: begin
                        we_a      <= 1'b1;
                        addr_a    <= wr_ptr;
                        w_data_a  <= rx_data[DataBusWidth-1:0];
                        wr_ptr    <= wr_ptr + AddrBusWidth'(1);
                        remaining <= remaining - 8'd1;
                        checksum  <= checksum ^ rx_data;
                        if (remaining == 8'd1) begin
                            state <= CHECK;
                        end
                    end
                    CHECK: begin
                        if (rx_data == checksum) begin
                            frame_ok <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end else if (timer_expired) begin
                frame_err <= 1'b1;
                state     <= IDLE;
                busy      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pattern_loader.sv
// Scoreboarded bench for pattern_loader: expected writes queued per frame,
// observed writes captured by a monitor and matched with their latency.
module tb_pattern_loader;

    localparam int AW = 6;
    localparam int DW = 4;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic [AW-1:0] addr_a;
    logic          we_a;
    logic [DW-1:0] w_data_a;
    logic          busy;
    logic          frame_ok;
    logic          frame_err;

    pattern_loader #(
        .AddrBusWidth  (AW),
        .DataBusWidth  (DW),
        .TimeoutCycles (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .addr_a    (addr_a),
        .we_a      (we_a),
        .w_data_a  (w_data_a),
        .busy      (busy),
        .frame_ok  (frame_ok),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            idx;
    } wr_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            cyc;
    } obs_t;

    int         cyc = 0;
    int         ok_cnt = 0;
    int         err_cnt = 0;
    obs_t       obs_q[$];
    wr_t        exp_q[$];
    logic [7:0] tx[$];
    int         byte_cyc[0:63];
    int         obs_rd = 0;
    int         checks = 0;
    int         passes = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (frame_ok === 1'b1) ok_cnt <= ok_cnt + 1;
        if (frame_err === 1'b1) err_cnt <= err_cnt + 1;
        if (we_a === 1'b1) obs_q.push_back('{addr: addr_a, data: w_data_a, cyc: cyc});
    end

    task automatic expect_wr(input int a, input int d, input int idx);
        wr_t e;
        e.addr = AW'(a);
        e.data = DW'(d);
        e.idx  = idx;
        exp_q.push_back(e);
    endtask

    task automatic drive_stream();
        for (int i = 0; i < tx.size(); i++) begin
            @(negedge clk);
            rx_data  = tx[i];
            rx_valid = 1'b1;
            byte_cyc[i] = cyc;
        end
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx.delete();
    endtask

    // Drains the expected-write queue against what the monitor captured.
    task automatic score_writes(input string name);
        wr_t  e;
        obs_t o;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_rd >= obs_q.size()) begin
                $display("FAIL %s_write: no write seen, required addr=%0h data=%0h", name, e.addr, e.data);
            end else begin
                o = obs_q[obs_rd];
                obs_rd++;
                if (o.addr !== e.addr || o.data !== e.data || o.cyc !== byte_cyc[e.idx] + 1) begin
                    $display("FAIL %s_write: got addr=%0h data=%0h cyc=%0d, required addr=%0h data=%0h cyc=%0d",
                             name, o.addr, o.data, o.cyc, e.addr, e.data, byte_cyc[e.idx] + 1);
                end else begin
                    passes++;
                end
            end
        end
        checks++;
        if (obs_rd != obs_q.size()) begin
            $display("FAIL %s_extra_writes: got %0d unexpected writes, required 0", name, obs_q.size() - obs_rd);
            obs_rd = obs_q.size();
        end else begin
            passes++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (addr_a !== '0 || we_a !== 1'b0 || w_data_a !== '0) begin
            $display("FAIL reset_write_port: got addr=%0h we=%0b data=%0h, required 0 0 0", addr_a, we_a, w_data_a);
        end else passes++;
        checks++;
        if (busy !== 1'b0 || frame_ok !== 1'b0 || frame_err !== 1'b0) begin
            $display("FAIL reset_status: got busy=%0b ok=%0b err=%0b, required 0 0 0", busy, frame_ok, frame_err);
        end else passes++;
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_frame();
        int ok0 = ok_cnt;
        int err0 = err_cnt;
        tx = '{8'hA5, 8'h04, 8'h02, 8'h03, 8'h0C, 8'h09};
        expect_wr(4, 3, 3);
        expect_wr(5, 12, 4);
        drive_stream();
        checks++;
        if (frame_ok !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL single_status: got ok=%0b busy=%0b, required ok=1 busy=0", frame_ok, busy);
        end else passes++;
        repeat (2) @(negedge clk);
        checks++;
        if (ok_cnt - ok0 != 1 || err_cnt - err0 != 0) begin
            $display("FAIL single_pulses: got ok=%0d err=%0d, required ok=1 err=0", ok_cnt - ok0, err_cnt - err0);
        end else passes++;
        score_writes("single");
    endtask

    task automatic test_wrap();
        int ok0 = ok_cnt;
        int err0 = err_cnt;
        tx = '{8'hA5, 8'h3F, 8'h02, 8'h01, 8'h02, 8'h3E};
        expect_wr(63, 1, 3);
        expect_wr(0, 2, 4);
        drive_stream();
        repeat (2) @(negedge clk);
        checks++;
        if (ok_cnt - ok0 != 1 || err_cnt - err0 != 0) begin
            $display("FAIL wrap_pulses: got ok=%0d err=%0d, required ok=1 err=0", ok_cnt - ok0, err_cnt - err0);
        end else passes++;
        score_writes("wrap");
    endtask

    task automatic test_bad_checksum();
        int ok0 = ok_cnt;
        int err0 = err_cnt;
        tx = '{8'hA5, 8'h00, 8'h01, 8'h07, 8'h00};
        expect_wr(0, 7, 3);
        drive_stream();
        checks++;
        if (frame_err !== 1'b1 || frame_ok !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL badchk_status: got err=%0b ok=%0b busy=%0b, required 1 0 0", frame_err, frame_ok, busy);
        end else passes++;
        repeat (2) @(negedge clk);
        checks++;
        if (ok_cnt - ok0 != 0 || err_cnt - err0 != 1) begin
            $display("FAIL badchk_pulses: got ok=%0d err=%0d, required ok=0 err=1", ok_cnt - ok0, err_cnt - err0);
        end else passes++;
        score_writes("badchk");
    endtask

    task automatic test_timeout();
        int fire_cyc;
        tx = '{8'hA5, 8'h00, 8'h03, 8'h05};
        expect_wr(0, 5, 3);
        drive_stream();
        for (int k = 0; k < 4 * TO && frame_err !== 1'b1; k++) @(negedge clk);
        fire_cyc = cyc;
        checks++;
        if (frame_err !== 1'b1) begin
            $display("FAIL timeout_fire: got no frame_err within %0d cycles, required one", 4 * TO);
        end else if (fire_cyc != byte_cyc[3] + TO || busy !== 1'b0) begin
            $display("FAIL timeout_fire: got delay=%0d busy=%0b, required delay=%0d busy=0",
                     fire_cyc - byte_cyc[3], busy, TO);
        end else passes++;
        @(negedge clk);
        checks++;
        if (frame_err !== 1'b0) begin
            $display("FAIL timeout_pulse_width: got err=%0b one cycle later, required 0", frame_err);
        end else passes++;
        score_writes("timeout");
    endtask

    task automatic test_ignore_noise();
        int ok0 = ok_cnt;
        int err0 = err_cnt;
        tx = '{8'h11, 8'h22, 8'hA5, 8'h01, 8'h00, 8'h01};
        drive_stream();
        checks++;
        if (frame_ok !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL noise_status: got ok=%0b busy=%0b, required ok=1 busy=0", frame_ok, busy);
        end else passes++;
        repeat (2) @(negedge clk);
        checks++;
        if (ok_cnt - ok0 != 1 || err_cnt - err0 != 0) begin
            $display("FAIL noise_pulses: got ok=%0d err=%0d, required ok=1 err=0", ok_cnt - ok0, err_cnt - err0);
        end else passes++;
        score_writes("noise");
    endtask

    task automatic test_back_to_back();
        int ok0 = ok_cnt;
        int err0 = err_cnt;
        tx = '{8'hA5, 8'h04, 8'h02, 8'h03, 8'h0C, 8'h09,
               8'hA5, 8'h08, 8'h01, 8'h0F, 8'h06};
        expect_wr(4, 3, 3);
        expect_wr(5, 12, 4);
        expect_wr(8, 15, 9);
        drive_stream();
        checks++;
        if (frame_ok !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL b2b_status: got ok=%0b busy=%0b, required ok=1 busy=0", frame_ok, busy);
        end else passes++;
        repeat (2) @(negedge clk);
        checks++;
        if (ok_cnt - ok0 != 2 || err_cnt - err0 != 0) begin
            $display("FAIL b2b_pulses: got ok=%0d err=%0d, required ok=2 err=0", ok_cnt - ok0, err_cnt - err0);
        end else passes++;
        score_writes("b2b");
    endtask

    task automatic test_reset_mid_frame();
        int ok0;
        int err0;
        tx = '{8'hA5, 8'h10, 8'h06, 8'h01, 8'h02};
        expect_wr(16, 1, 3);
        expect_wr(17, 2, 4);
        drive_stream();
        rst      = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'h03;
        @(negedge clk);
        rst      = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        checks++;
        if (addr_a !== '0 || we_a !== 1'b0 || w_data_a !== '0 ||
            busy !== 1'b0 || frame_ok !== 1'b0 || frame_err !== 1'b0) begin
            $display("FAIL midrst_outputs: got addr=%0h we=%0b data=%0h busy=%0b ok=%0b err=%0b, required all 0",
                     addr_a, we_a, w_data_a, busy, frame_ok, frame_err);
        end else passes++;
        repeat (2 * TO) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || frame_err !== 1'b0) begin
            $display("FAIL midrst_idle: got busy=%0b err=%0b, required 0 0", busy, frame_err);
        end else passes++;
        score_writes("midrst");
        ok0  = ok_cnt;
        err0 = err_cnt;
        tx = '{8'hA5, 8'h20, 8'h01, 8'h09, 8'h28};
        expect_wr(32, 9, 3);
        drive_stream();
        repeat (2) @(negedge clk);
        checks++;
        if (ok_cnt - ok0 != 1 || err_cnt - err0 != 0) begin
            $display("FAIL midrst_recover: got ok=%0d err=%0d, required ok=1 err=0", ok_cnt - ok0, err_cnt - err0);
        end else passes++;
        score_writes("recover");
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_wrap();
        test_bad_checksum();
        test_timeout();
        test_ignore_noise();
        test_back_to_back();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1);
    end

endmodule

// File: doc/pattern_loader.md
# pattern_loader

Byte-stream frame parser that writes incoming pattern words into the pattern RAM's write port (port A of `sdpram`). It is the writer counterpart to the playback path that reads port B. It sits between a UART receive byte stream (`rx_data`/`rx_valid`) and `addr_a`/`we_a`/`w_data_a`. The block validates each frame with an XOR checksum, aborts stalled frames on a timeout, and reports status by pulse.

## Interface
- `AddrBusWidth`, default 6: pattern RAM address width; must be ≤ 8.
- `DataBusWidth`, default 4: pattern word width; must be ≤ 8.
- `TimeoutCycles`, default 1_000_000: idle cycles tolerated between bytes inside a frame; must be ≥ 2.
- `clk`, input, 1: sole clock; everything is on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `rx_data`, input, 8: received byte; valid only when `rx_valid` is high.
- `rx_valid`, input, 1: one-cycle strobe per byte; may be high on consecutive cycles.
- `addr_a`, output, AddrBusWidth: RAM write address.
- `we_a`, output, 1: RAM write enable, a one-cycle pulse per data word.
- `w_data_a`, output, DataBusWidth: RAM write data.
- `busy`, output, 1: high in every state except IDLE.
- `frame_ok`, output, 1: one-cycle pulse when the checksum matches.
- `frame_err`, output, 1: one-cycle pulse on checksum mismatch or timeout.

## Operation
- Frame format: SYNC (0xA5), ADDR, COUNT, COUNT data bytes, CHK.
- Only the low `AddrBusWidth` bits of ADDR are used; the upper bits are ignored.
- Each data byte carries one word in its low `DataBusWidth` bits; the upper bits are ignored for the write but included in the checksum.
- CHK must equal ADDR ^ COUNT ^ data[0] ^ … ^ data[COUNT-1], computed over full 8-bit bytes. SYNC is excluded.
- States and transitions:
  - IDLE: a byte equal to 0xA5 moves to ADDR. Any other byte is dropped silently, with no error.
  - ADDR: latch the write pointer and initialise the running checksum to ADDR; go to COUNT.
  - COUNT: latch the remaining count and XOR it into the checksum. If COUNT = 0, go to CHECK; otherwise go to DATA.
  - DATA: each byte issues one write at the current pointer. The pointer then increments modulo 2^AddrBusWidth, wrapping 63→0 at default width. The remaining count decrements; when it reaches 0, go to CHECK.
  - CHECK: compare the received byte with the running checksum. Pulse `frame_ok` on a match, `frame_err` otherwise. Go to IDLE either way.
- Writes are issued as data arrives; nothing is buffered. On a checksum failure or timeout, words already written stay in RAM. The error pulse is the only indication.
- Timeout: outside IDLE, a counter clears on every accepted byte and increments each cycle without one. When it reaches `TimeoutCycles`-1, pulse `frame_err` and return to IDLE.
- If `rx_valid` arrives on the same cycle the timeout would fire, the byte wins and the timeout does not fire.
- A byte 0xA5 received outside IDLE is treated as ordinary payload. There is no resynchronisation mid-frame.

## Timing
- Every output is registered.
- Reset values: `addr_a` = 0, `we_a` = 0, `w_data_a` = 0, `busy` = 0, `frame_ok` = 0, `frame_err` = 0. State is IDLE, checksum is 0, and the timeout counter is 0.
- Data byte accepted at cycle n: `we_a` is high at n+1, with `addr_a`/`w_data_a` valid in that same cycle.
- With back-to-back data bytes, `we_a` stays high for consecutive cycles and the address increments every cycle.
- CHK byte accepted at cycle n: `frame_ok` or `frame_err` is high at n+1, and `busy` is low at n+1.
- Timeout: `frame_err` is high exactly `TimeoutCycles` cycles after the last accepted byte.
- `busy` rises the cycle after SYNC is accepted. A new SYNC accepted on the cycle after CHK starts the next frame with no dead cycle.
- `rst` asserted mid-frame: the next cycle is IDLE with all outputs at reset values. Any in-flight `we_a` is suppressed. RAM contents are untouched.

## Structure
- Shared package `pattern_loader_pkg`: the state enum (IDLE, ADDR, COUNT, DATA, CHECK) and the `SyncByte` = 8'hA5 constant.
- Sub-module `timeout_timer`: a parameterised down-counter with inputs `clk`, `rst`, `restart`, `enable` and output `expired`. It is instantiated once and is reusable by the future UART receiver.
- The FSM, write pointer, remaining-count register and checksum accumulator live in `pattern_loader`.

## Test plan
- Frame A5 04 02 03 0C 09 → writes 3@4 and C@5 on two consecutive `we_a` cycles. 09 = 04^02^03^0C, so `frame_ok` pulses once.
- Frame A5 3F 02 01 02 3E (default widths) → writes 1@63 then 2@0, checking pointer wrap; `frame_ok` pulses.
- Frame A5 00 01 07 00 (bad CHK; correct value is 06) → writes 7@0, `frame_err` pulses, `frame_ok` stays low.
- With `TimeoutCycles` = 16: send A5 00 03 05, then stall → one write (5@0). `frame_err` fires 16 cycles after the 05 byte and `busy` drops.
- Bytes 11 22 then frame A5 01 00 01 → bytes 11 and 22 are ignored, no write occurs, and `frame_ok` pulses.
- Assert `rst` for one cycle mid-DATA in a back-to-back frame → no `we_a` after reset, all outputs 0, and a following valid frame is accepted normally.
